// File: rtl/stdp_update_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stdp_pkg
// Brief    : Shared types and STDP pair classification for stdp_update_gen.
// Revision : 1.0 - initial release
// ============================================================================
package stdp_pkg;

    localparam int c_TIME_W_MAX = 16;

    typedef enum logic [1:0] {
        IDLE,
        WINDOW,
        UPDATE
    } state_t;

    typedef enum logic [2:0] {
        NONE,
        CAPTURE,
        BACKOFF,
        SEARCH,
        MINUS
    } upd_kind_t;

    // Coincident pre/post spikes count as causal, hence <= for CAPTURE.
    function automatic upd_kind_t classify(
        input logic                    pre_seen,
        input logic                    post_seen,
        input logic [c_TIME_W_MAX-1:0] t_pre,
        input logic [c_TIME_W_MAX-1:0] t_post
    );
        upd_kind_t w_kind;
        w_kind = NONE;
        if (pre_seen && post_seen) begin
            w_kind = (t_pre <= t_post) ? CAPTURE : BACKOFF;
        end else if (post_seen) begin
            w_kind = SEARCH;
        end else if (pre_seen) begin
            w_kind = MINUS;
        end
        return w_kind;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stdp_update_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : stdp_update_gen_if
// Brief    : Spike inputs and weight-update pulse outputs of stdp_update_gen.
// Revision : 1.0 - initial release
// ============================================================================
interface stdp_update_gen_if;

    logic gamma_start;
    logic pre_spike;
    logic post_spike;
    logic inc;
    logic dec;
    logic busy;

    modport master (
        output gamma_start, pre_spike, post_spike,
        input  inc, dec, busy
    );

    modport slave (
        input  gamma_start, pre_spike, post_spike,
        output inc, dec, busy
    );

endinterface
`default_nettype wire

// File: rtl/stdp_update_gen_latch.sv
`default_nettype none
// ============================================================================
// Module   : first_spike_latch
// Brief    : Records whether and when the first spike of a window occurred.
// Revision : 1.0 - initial release
// ============================================================================
module first_spike_latch #(
    parameter int TIME_W = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clear,
    input  wire logic              spike,
    input  wire logic [TIME_W-1:0] t,
    output logic                   seen,
    output logic [TIME_W-1:0]      t_first
);

    logic              r_seen;
    logic [TIME_W-1:0] r_t_first;

    // A clear cycle is also time 0 of the new window, so its spike is kept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_seen    <= 1'b0;
            r_t_first <= '0;
        end else if (clear) begin
            r_seen    <= spike;
            r_t_first <= spike ? t : '0;
        end else if (spike && !r_seen) begin
            r_seen    <= 1'b1;
            r_t_first <= t;
        end
    end

    assign seen    = r_seen;
    assign t_first = r_t_first;

endmodule
`default_nettype wire

// File: rtl/stdp_update_gen.sv
`default_nettype none
// ============================================================================
// Module   : stdp_update_gen
// Brief    : Times first pre/post spikes per gamma window and emits STDP
//            inc/dec pulse bursts for a downstream weight counter.
// Revision : 1.0 - initial release
// ============================================================================
module stdp_update_gen
    import stdp_pkg::*;
#(
    parameter int GAMMA_LEN = 16,
    parameter int STEP      = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    stdp_update_gen_if.slave  bus
);

    localparam int TIME_W                    = (GAMMA_LEN > 1) ? $clog2(GAMMA_LEN) : 1;
    localparam int c_PCNT_W                  = 3;
    localparam logic [TIME_W-1:0]   c_T_LAST = TIME_W'(GAMMA_LEN - 1);
    localparam logic [c_PCNT_W-1:0] c_P_LAST = c_PCNT_W'(STEP - 1);

    state_t                r_state;
    logic [TIME_W-1:0]     r_t;
    logic [c_PCNT_W-1:0]   r_pcnt;
    logic                  r_inc;
    logic                  r_dec;

    logic                  w_start;
    logic                  w_sampling;
    logic                  w_last;
    logic [TIME_W-1:0]     w_t;
    logic                  w_pre_spk;
    logic                  w_post_spk;
    logic                  w_pre_seen;
    logic                  w_post_seen;
    logic [TIME_W-1:0]     w_t_pre;
    logic [TIME_W-1:0]     w_t_post;
    upd_kind_t             w_kind;

    assign w_start    = bus.gamma_start;
    assign w_sampling = w_start || (r_state == WINDOW);
    assign w_t        = w_start ? '0 : r_t;
    assign w_pre_spk  = w_sampling && bus.pre_spike;
    assign w_post_spk = w_sampling && bus.post_spike;
    assign w_last     = (r_state == WINDOW) && !w_start && (r_t == c_T_LAST);

    first_spike_latch #(.TIME_W(TIME_W)) u_pre_latch (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_start),
        .spike   (w_pre_spk),
        .t       (w_t),
        .seen    (w_pre_seen),
        .t_first (w_t_pre)
    );

    first_spike_latch #(.TIME_W(TIME_W)) u_post_latch (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_start),
        .spike   (w_post_spk),
        .t       (w_t),
        .seen    (w_post_seen),
        .t_first (w_t_post)
    );

    // Spikes in the final window cycle are not latched yet, so fold them in here.
    always_comb begin
        w_kind = classify(
            w_pre_seen  || w_pre_spk,
            w_post_seen || w_post_spk,
            c_TIME_W_MAX'(w_pre_seen  ? w_t_pre  : w_t),
            c_TIME_W_MAX'(w_post_seen ? w_t_post : w_t)
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_pcnt  <= '0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
        end else if (w_start) begin
            r_state <= WINDOW;
            r_t     <= TIME_W'(1);
            r_pcnt  <= '0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_t <= '0;
                end
                WINDOW: begin
                    if (w_last) begin
                        r_t    <= '0;
                        r_pcnt <= '0;
                        case (w_kind)
                            CAPTURE, SEARCH: begin
                                r_state <= UPDATE;
                                r_inc   <= 1'b1;
                            end
                            BACKOFF, MINUS: begin
                                r_state <= UPDATE;
                                r_dec   <= 1'b1;
                            end
                            default: r_state <= IDLE;
                        endcase
                    end else begin
                        r_t <= r_t + TIME_W'(1);
                    end
                end
                UPDATE: begin
                    if (r_pcnt == c_P_LAST) begin
                        r_state <= IDLE;
                        r_inc   <= 1'b0;
                        r_dec   <= 1'b0;
                    end else begin
                        r_pcnt <= r_pcnt + c_PCNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.inc  = r_inc;
    assign bus.dec  = r_dec;
    assign bus.busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_stdp_update_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_stdp_update_gen
// Brief    : Directed-vector bench for stdp_update_gen (GAMMA_LEN=16, STEP=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stdp_update_gen;

    localparam int c_GAMMA = 16;
    localparam int c_STEP  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    stdp_update_gen_if bus_if ();

    stdp_update_gen #(
        .GAMMA_LEN (c_GAMMA),
        .STEP      (c_STEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rng(input int a, input int b);
        logic [63:0] m;
        m = '0;
        for (int i = a; i <= b; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic g, input logic p, input logic q);
        bus_if.gamma_start = g;
        bus_if.pre_spike   = p;
        bus_if.post_spike  = q;
    endtask

    // Cycle n of a vector: drive bit n of the stimulus masks, check bit n of
    // the expected masks, then advance. dc masks out inc/dec checks.
    task automatic run_vec(input string name, input int ncyc,
                           input logic [63:0] st, input logic [63:0] pr, input logic [63:0] po,
                           input logic [63:0] ei, input logic [63:0] ed, input logic [63:0] eb,
                           input logic [63:0] dc);
        for (int n = 0; n < ncyc; n++) begin
            drive(st[n], pr[n], po[n]);
            if (!dc[n]) begin
                check_eq($sformatf("%s inc c%0d", name, n), 64'(bus_if.inc), 64'(ei[n]));
                check_eq($sformatf("%s dec c%0d", name, n), 64'(bus_if.dec), 64'(ed[n]));
            end
            check_eq($sformatf("%s busy c%0d", name, n), 64'(bus_if.busy), 64'(eb[n]));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Reset held low while inputs toggle
        for (int n = 0; n < 3; n++) begin
            drive(n[0], ~n[0], 1'b1);
            check_eq($sformatf("rst inc c%0d", n), 64'(bus_if.inc), 64'(0));
            check_eq($sformatf("rst dec c%0d", n), 64'(bus_if.dec), 64'(0));
            check_eq($sformatf("rst busy c%0d", n), 64'(bus_if.busy), 64'(0));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // Spikes without gamma_start must not wake the block
        for (int n = 0; n < 3; n++) begin
            drive(1'b0, 1'b1, n[0]);
            check_eq($sformatf("idle inc c%0d", n), 64'(bus_if.inc), 64'(0));
            check_eq($sformatf("idle dec c%0d", n), 64'(bus_if.dec), 64'(0));
            check_eq($sformatf("idle busy c%0d", n), 64'(bus_if.busy), 64'(0));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        tick();

        run_vec("cap", 20, rng(0,0), rng(3,3), rng(7,7),
                rng(16,17), '0, rng(1,17), '0);
        run_vec("cap_same", 20, rng(0,0), rng(6,6) | rng(10,10), rng(6,6) | rng(12,12),
                rng(16,17), '0, rng(1,17), '0);
        run_vec("backoff", 20, rng(0,0), rng(9,9), rng(4,4),
                '0, rng(16,17), rng(1,17), '0);
        run_vec("search15", 20, rng(0,0), '0, rng(15,15),
                rng(16,17), '0, rng(1,17), '0);
        run_vec("minus0", 20, rng(0,0), rng(0,0), '0,
                '0, rng(16,17), rng(1,17), '0);
        run_vec("none", 18, rng(0,0), '0, '0,
                '0, '0, rng(1,15), '0);
        run_vec("abort_win", 30, rng(0,0) | rng(10,10), rng(2,2), rng(10,10),
                rng(26,27), '0, rng(1,27), '0);
        run_vec("abort_burst", 37, rng(0,0) | rng(17,17), rng(3,3) | rng(17,17), rng(7,7) | rng(17,17),
                rng(16,16) | rng(33,34), '0, rng(1,34), rng(17,17));
        run_vec("b2b", 38, rng(0,0) | rng(18,18), rng(3,3) | rng(27,27), rng(7,7) | rng(22,22),
                rng(16,17), rng(34,35), rng(1,17) | rng(19,35), '0);

        // Reset sampled low in the first pulse cycle
        run_vec("rstb", 16, rng(0,0), rng(3,3), rng(7,7), '0, '0, rng(1,15), '0);
        rst = 1'b0;
        check_eq("rstb inc c16", 64'(bus_if.inc), 64'(1));
        check_eq("rstb busy c16", 64'(bus_if.busy), 64'(1));
        tick();
        rst = 1'b1;
        check_eq("rstb inc c17", 64'(bus_if.inc), 64'(0));
        check_eq("rstb dec c17", 64'(bus_if.dec), 64'(0));
        check_eq("rstb busy c17", 64'(bus_if.busy), 64'(0));
        tick();
        check_eq("rstb inc c18", 64'(bus_if.inc), 64'(0));
        check_eq("rstb busy c18", 64'(bus_if.busy), 64'(0));
        tick();

        run_vec("post_rst", 20, rng(0,0), rng(9,9), rng(4,4),
                '0, rng(16,17), rng(1,17), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stdp_update_gen.md
# stdp_update_gen

Weight-update pulse generator that sits directly upstream of the binary pulse-encoded synaptic weight counter. It times the first pre-synaptic and first post-synaptic spike inside each gamma window and classifies the pair with the STDP rule (capture / backoff / search / minus). At window end it emits a burst of STEP one-cycle `inc` or `dec` pulses that drive the counter's `inc`/`dec` inputs; saturation is left to the counter.

## Interface
Parameters:
- GAMMA_LEN, 16: cycles per gamma window, ≥2.
- STEP, 1: pulses per update, 1..7.
- TIME_W, $clog2(GAMMA_LEN): spike-time field width (derived, not overridden).

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  reset, synchronous, active-low.
- gamma_start  in  1  one-cycle marker of window time 0.
- pre_spike  in  1  pre-synaptic spike, level sampled each cycle.
- post_spike  in  1  post-synaptic (neuron output) spike.
- inc  out  1  increment pulse to weight counter, registered.
- dec  out  1  decrement pulse to weight counter, registered.
- busy  out  1  high in WINDOW or UPDATE.

## Operation
- States: IDLE, WINDOW, UPDATE.
- IDLE: gamma_start → WINDOW. Spikes are ignored.
- WINDOW: time counter t runs 0..GAMMA_LEN-1; t=0 is the cycle gamma_start is high. Spikes sampled in that cycle count as t=0.
- First pre spike latches t_pre and pre_seen. First post spike latches t_post and post_seen. Later spikes in the same window are ignored.
- At t=GAMMA_LEN-1 (spikes in that cycle still count), classify:
  - CAPTURE: pre_seen & post_seen & t_pre≤t_post → inc. Same-cycle pre/post is capture.
  - BACKOFF: pre_seen & post_seen & t_pre>t_post → dec.
  - SEARCH: post_seen & !pre_seen → inc.
  - MINUS: pre_seen & !post_seen → dec.
  - NONE: no spikes → go directly to IDLE, no pulses.
- UPDATE: assert the selected output for exactly STEP consecutive cycles (pulse counter 0..STEP-1), then IDLE.
- `inc` and `dec` are never high together. Both are 0 outside UPDATE.
- gamma_start in WINDOW or UPDATE aborts the current window or burst:
  - remaining pulses are dropped;
  - latches are cleared, then that cycle's spikes are captured;
  - t restarts at 0 and the state goes to WINDOW.
- rst=0 at any posedge: state IDLE, counters and latches cleared. Takes priority over gamma_start.

## Timing
- Reset values: inc=0, dec=0, busy=0, state IDLE.
- gamma_start in cycle c: busy is high from cycle c+1. The window covers cycles c..c+GAMMA_LEN-1.
- Update pulses are high in cycles c+GAMMA_LEN .. c+GAMMA_LEN+STEP-1.
- busy falls in cycle c+GAMMA_LEN+STEP, or in cycle c+GAMMA_LEN for NONE.
- Back-to-back windows: gamma_start may be asserted in the cycle after the last pulse.
- Reset mid-burst: outputs are 0 in the cycle after rst is sampled low.
- Time compare is unsigned TIME_W-bit. Counter t never wraps inside a window.

## Structure
- Package `stdp_pkg`:
  - state enum {IDLE, WINDOW, UPDATE};
  - update-kind enum {NONE, CAPTURE, BACKOFF, SEARCH, MINUS};
  - a pure function classify(pre_seen, post_seen, t_pre, t_post) returning the kind.
- Sub-module `first_spike_latch`, instantiated twice (pre and post). Ports: clk, rst, clear, spike, t; outputs seen, t_first.
- Top holds the FSM, window counter, pulse counter and output registers.

## Test plan
GAMMA_LEN=16, STEP=2. Cycle numbers are relative to the gamma_start cycle (=0).
- Reset: hold rst=0 for 3 cycles while toggling gamma_start and spikes → inc=dec=busy=0 throughout. Release → still 0 until gamma_start.
- Capture: pre at 3, post at 7 → inc=1 in cycles 16 and 17, dec=0, busy=0 at cycle 18. Repeat with pre and post both at 6, plus extra pre at 10 and post at 12 → same inc burst.
- Backoff: pre at 9, post at 4 → dec=1 in cycles 16 and 17, inc=0.
- Single-sided:
  - post only at 15 (last window cycle) → inc in cycles 16 and 17;
  - pre only at 0 → dec in cycles 16 and 17;
  - no spikes → no pulses, busy=0 at cycle 16.
- Abort / back-to-back:
  - pre at 2, then gamma_start again at 10 with post at 10 → only search counts: inc in cycles 26 and 27.
  - gamma_start at 17 during a burst → cycle-17 pulse dropped, new window starts.
- Reset mid-burst: capture window, rst=0 sampled at cycle 16 → inc=0 from cycle 17, busy=0. The next gamma_start behaves normally.
